// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Control side of the EX-stage 3:1 operand forwarding muxes. Tracks
//   destination-register metadata through ID/EX, EX/MEM and MEM/WB. Produces
//   the forward selects for ALU operands A and B. Detects load-use hazards
//   and bubbles its own ID/EX slot. Counts stalls in a saturating counter.
//
//   Select encoding: 00 = register file, 01 = MEM/WB result,
//                    10 = EX/MEM result, 11 = never driven.
//
// Ports
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   id_*_in                   decoded metadata of the instruction in ID
//   flush_in                  squash the ID instruction (taken branch/jump)
//   Forward_A_out/_B_out      operand mux selects for the instruction in EX
//   stall_out                 freeze PC and IF/ID this cycle
//   stall_count_out           load-use stalls since reset, saturating

// One operand's forward select. It is instantiated once per ALU operand.
module fwd_sel #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  src_valid,
  input  logic                  src_use,
  input  logic [REG_ADDR_W-1:0] src_reg,
  input  logic                  exmem_rw,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_rw,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output logic [1:0]            sel
);
  logic need;
  assign need = src_valid & src_use;

  // EX/MEM is checked first because it holds the newer value.
  // Register 0 is hard-wired, so it is never forwarded.
  always_comb begin
    sel = 2'b00;
    if (need & exmem_rw & (exmem_rd != '0) & (exmem_rd == src_reg))
      sel = 2'b10;
    else if (need & memwb_rw & (memwb_rd != '0) & (memwb_rd == src_reg))
      sel = 2'b01;
  end
endmodule

module fwd_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   id_valid_in,
  input  logic [REG_ADDR_W-1:0]  id_rs_in,
  input  logic [REG_ADDR_W-1:0]  id_rt_in,
  input  logic                   id_uses_rs_in,
  input  logic                   id_uses_rt_in,
  input  logic [REG_ADDR_W-1:0]  id_rd_in,
  input  logic                   id_reg_write_in,
  input  logic                   id_mem_read_in,
  input  logic                   flush_in,
  output logic [1:0]             Forward_A_out,
  output logic [1:0]             Forward_B_out,
  output logic                   stall_out,
  output logic [STALL_CNT_W-1:0] stall_count_out
);
  localparam int NUM_OPS = 2;  // operand A, operand B

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  uses_rs;
    logic                  uses_rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } idex_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } wb_t;

  idex_t                  idex, idex_d;
  wb_t                    exmem, memwb;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   bubble;

  // A load in ID/EX whose result the ID instruction needs. The value is not
  // available until MEM/WB, so the consumer has to wait one cycle.
  assign stall_out = idex.valid & idex.mem_read & (idex.rd != '0) & id_valid_in &
                     ((id_uses_rs_in & (id_rs_in == idex.rd)) |
                      (id_uses_rt_in & (id_rt_in == idex.rd)));

  assign bubble = stall_out | flush_in | ~id_valid_in;

  always_comb begin
    idex_d.valid     = id_valid_in;
    idex_d.rs        = id_rs_in;
    idex_d.rt        = id_rt_in;
    idex_d.uses_rs   = id_uses_rs_in;
    idex_d.uses_rt   = id_uses_rt_in;
    idex_d.rd        = id_rd_in;
    idex_d.reg_write = id_reg_write_in;
    idex_d.mem_read  = id_mem_read_in;
    if (bubble) begin
      idex_d.valid     = 1'b0;
      idex_d.reg_write = 1'b0;
      idex_d.mem_read  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      idex      <= '0;
      exmem     <= '0;
      memwb     <= '0;
      stall_cnt <= '0;
    end else begin
      memwb     <= exmem;
      exmem     <= '{rd: idex.rd, reg_write: idex.reg_write, mem_read: idex.mem_read};
      idex      <= idex_d;
      if (stall_out && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_count_out = stall_cnt;

  // The mem_read bit rides along in the later slots for debug visibility.
  // No logic here consumes it.
  logic unused_mem_read;
  assign unused_mem_read = exmem.mem_read ^ memwb.mem_read;

  // Per-operand select lanes: lane 0 uses rs, lane 1 uses rt.
  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_reg;
  logic [NUM_OPS-1:0]                 op_use;
  logic [NUM_OPS-1:0][1:0]            op_sel;

  assign op_reg = {idex.rt, idex.rs};
  assign op_use = {idex.uses_rt, idex.uses_rs};

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
        .src_valid (idex.valid),
        .src_use   (op_use[g]),
        .src_reg   (op_reg[g]),
        .exmem_rw  (exmem.reg_write),
        .exmem_rd  (exmem.rd),
        .memwb_rw  (memwb.reg_write),
        .memwb_rd  (memwb.rd),
        .sel       (op_sel[g])
      );
    end
  endgenerate

  assign Forward_A_out = op_sel[0];
  assign Forward_B_out = op_sel[1];
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Control-side counterpart of the 3:1 forwarding muxes in EX. Tracks destination-register metadata through ID/EX, EX/MEM and MEM/WB.
- Generates the 2-bit forward selects for ALU operands A and B.
- Detects load-use hazards, requests a one-cycle stall and inserts a bubble into its own ID/EX tracking.
- Keeps a saturating stall counter for performance checks.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk_in  input  1  rising-edge clock
- rst_n_in  input  1  synchronous active-low reset
- id_valid_in  input  1  ID stage holds a real instruction
- id_rs_in  input  REG_ADDR_W  ID source register rs
- id_rt_in  input  REG_ADDR_W  ID source register rt
- id_uses_rs_in  input  1  ID instruction reads rs
- id_uses_rt_in  input  1  ID instruction reads rt
- id_rd_in  input  REG_ADDR_W  ID destination register (already muxed rd/rt)
- id_reg_write_in  input  1  ID instruction writes the register file
- id_mem_read_in  input  1  ID instruction is a load
- flush_in  input  1  taken branch/jump; squash the ID instruction
- Forward_A_out  output  2  select for operand-A mux
- Forward_B_out  output  2  select for operand-B mux
- stall_out  output  1  freeze PC and IF/ID this cycle
- stall_count_out  output  STALL_CNT_W  load-use stalls since reset, saturating

Behaviour:
- Select encoding, which must match the EX muxes:
  - 00 = register file data
  - 01 = MEM_WB result
  - 10 = EX_MEM result
  - 11 is never driven.
- Internal state is three stage slots: IDEX, EXMEM and MEMWB. Each slot holds {valid, rs, rt, uses_rs, uses_rt, rd, reg_write, mem_read}. EXMEM and MEMWB only need {rd, reg_write, mem_read}.
- Reset (rst_n_in=0 at a rising edge):
  - all slot valid/reg_write/mem_read bits cleared; counter cleared.
  - Forward_A_out and Forward_B_out = 00; stall_out = 0 from the following cycle.
  - Reset overrides stall and flush in the same cycle.
- Every non-reset edge:
  - MEMWB <= EXMEM.
  - EXMEM <= IDEX.
  - IDEX <= ID inputs, except that a bubble (valid=0, reg_write=0, mem_read=0) is loaded instead when any of these holds: stall_out=1, flush_in=1, or id_valid_in=0.
- Forward select for operand A is combinational from the slots (operand B is identical using rt/uses_rt):
  - 10 if IDEX.valid & IDEX.uses_rs & EXMEM.reg_write & EXMEM.rd!=0 & EXMEM.rd==IDEX.rs.
  - else 01 if IDEX.valid & IDEX.uses_rs & MEMWB.reg_write & MEMWB.rd!=0 & MEMWB.rd==IDEX.rs.
  - else 00.
  - EX_MEM has priority because it holds the newest value.
  - Register 0 is never forwarded.
- Latency: a producer captured into IDEX at edge N is seen as EXMEM by its consumer at edge N+1, giving select 10. At edge N+2 it is seen as MEMWB, giving select 01.
- stall_out is combinational: IDEX.valid & IDEX.mem_read & IDEX.rd!=0 & id_valid_in & ((id_uses_rs_in & id_rs_in==IDEX.rd) | (id_uses_rt_in & id_rt_in==IDEX.rd)).
  - While stalled, upstream holds the ID inputs stable and the bubble occupies IDEX.
  - The next cycle re-evaluates. The load is then in EXMEM, so the stall drops and the consumer later gets select 01 from MEMWB.
- flush_in has priority over stall_out for the IDEX load (both give a bubble). stall_out is still reported when its condition holds.
- Counter increments by 1 on each edge where stall_out=1 and rst_n_in=1. It holds at all-ones: 2^STALL_CNT_W-1 stays there.
- No write-back-to-ID bypass; the register file is write-first.

Test Plan:
- Reset: hold rst_n_in=0 two cycles with a valid load in ID -> Forward_A/B=00, stall_out=0, stall_count_out=0 after the edge.
- EX hazard: add $3,$1,$2 then sub $4,$3,$5 on back-to-back cycles -> while sub is in IDEX, Forward_A_out=10, Forward_B_out=00.
- MEM hazard and priority:
  - add $3; nop; or $6,$3,$3 -> Forward_A_out=Forward_B_out=01.
  - add $3; add $3; sub $7,$3,$0 -> Forward_A_out=10 (EX_MEM wins).
- Zero register: add $0,$1,$2 then sub $4,$0,$0 -> both selects stay 00.
- Load-use:
  - lw $8,0($9) then add $10,$8,$1 -> stall_out=1 for exactly one cycle, stall_count_out 0->1.
  - A bubble enters IDEX. Next cycle stall_out=0, and when add reaches EX, Forward_A_out=01.
- Flush and saturation:
  - flush_in=1 with stall condition true -> IDEX bubble, no forwarding from the squashed instruction.
  - With STALL_CNT_W=2, force 5 stalls -> stall_count_out saturates at 3.
